// File: rtl/note_game_controller_pkg.sv
// Shared game constants, state encoding and geometry
// used by the controller and the VGA pixel painter.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam logic [11:0] BLACK = 12'h000;
  localparam logic [11:0] WHITE = 12'hFFF;
  localparam logic [11:0] RED   = 12'hF00;
  localparam logic [11:0] GREEN = 12'h0F0;

  localparam int H_MIN = 144;
  localparam int H_MAX = 784;

  localparam int NOTE_X0 = 340;
  localparam int NOTE_X1 = 380;
  localparam int NOTE_H  = 40;

  localparam int DEF_HIT_TOP = 400;
  localparam int DEF_HIT_BOT = 475;
  localparam int DEF_Y_MAX   = 779;
  localparam int DEF_START_Y = 320;

  function automatic logic in_win(
    input logic [9:0] y,
    input logic [9:0] top,
    input logic [9:0] bot
  );
    return (y >= top) && (y <= bot);
  endfunction

endpackage

// File: rtl/note_game_controller_if.sv
// Player/painter side bundle of the note game controller:
// start/button in, note position, score and status out.
interface note_game_controller_if;
  logic        start;
  logic        button;
  logic [9:0]  note_y;
  logic [15:0] score;
  logic [3:0]  misses;
  logic [1:0]  state;
  logic        hit_pulse;
  logic        miss_pulse;

  modport master (
    output start, button,
    input  note_y, score, misses, state,
    input  hit_pulse, miss_pulse
  );

  modport slave (
    input  start, button,
    output note_y, score, misses, state,
    output hit_pulse, miss_pulse
  );
endinterface

// File: rtl/note_game_controller_tick_divider.sv
// Note fall-rate divider: tick every DIV enabled cycles,
// count held at zero while disabled.
module tick_divider #(
  parameter int DIV = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);
  localparam int W = (DIV > 2) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt;

  assign tick = en && (cnt == W'(DIV - 1));

  // free-run while enabled, wrap on the terminal count
  always_ff @(posedge clk) begin
    if (reset || !en) cnt <= '0;
    else if (tick)    cnt <= '0;
    else              cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/note_game_controller.sv
// Falling-note rhythm game sequencer: state machine,
// note position, hit judging, score and miss counters.
module note_game_controller
  import game_pkg::*;
#(
  parameter int TICK_DIV   = 500000,
  parameter int Y_MAX      = DEF_Y_MAX,
  parameter int START_Y    = DEF_START_Y,
  parameter int HIT_TOP    = DEF_HIT_TOP,
  parameter int HIT_BOT    = DEF_HIT_BOT,
  parameter int MAX_MISSES = 3
) (
  input  logic clk,
  input  logic reset,
  note_game_controller_if.slave bus
);
  state_t      state_q, state_d;
  logic [9:0]  note_y_q, note_y_d;
  logic [15:0] score_q, score_d;
  logic [3:0]  misses_q, misses_d;
  logic        armed_q, armed_d;
  logic        btn_q;
  logic        hit_q, hit_d;
  logic        miss_q, miss_d;
  logic        tick, en, press;

  assign en    = (state_q == PLAY) && !bus.start;
  assign press = bus.button && !btn_q;

  tick_divider #(.DIV(TICK_DIV)) u_div (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .tick  (tick)
  );

  // state register; reset dominates everything
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      note_y_q <= 10'(START_Y);
      score_q  <= '0;
      misses_q <= '0;
      armed_q  <= 1'b1;
      btn_q    <= 1'b0;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      note_y_q <= note_y_d;
      score_q  <= score_d;
      misses_q <= misses_d;
      armed_q  <= armed_d;
      btn_q    <= bus.button;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
    end
  end

  // next state: start, hit judging and note stepping
  always_comb begin
    state_d  = state_q;
    note_y_d = note_y_q;
    score_d  = score_q;
    misses_d = misses_q;
    armed_d  = armed_q;
    hit_d    = 1'b0;
    miss_d   = 1'b0;
    if (bus.start) begin
      state_d  = PLAY;
      note_y_d = '0;
      score_d  = '0;
      misses_d = '0;
      armed_d  = 1'b1;
    end else begin
      unique case (1'b1)
        (state_q == PLAY): begin
          if (press && armed_q &&
              in_win(note_y_q, 10'(HIT_TOP), 10'(HIT_BOT))) begin
            if (score_q != 16'hFFFF) score_d = score_q + 16'd1;
            armed_d = 1'b0;
            hit_d   = 1'b1;
          end
          if (tick) begin
            if (note_y_q == 10'(Y_MAX)) begin
              note_y_d = '0;
              armed_d  = 1'b1;
              if (armed_q) begin
                misses_d = misses_q + 4'd1;
                miss_d   = 1'b1;
                if (misses_d == 4'(MAX_MISSES)) state_d = OVER;
              end
            end else begin
              note_y_d = note_y_q + 10'd1;
            end
          end
        end
        (state_q == IDLE),
        (state_q == OVER): ;
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.note_y     = note_y_q;
  assign bus.score      = score_q;
  assign bus.misses     = misses_q;
  assign bus.state      = state_q;
  assign bus.hit_pulse  = hit_q;
  assign bus.miss_pulse = miss_q;
endmodule

// File: tb/tb_note_game_controller.sv
// Directed vector bench for note_game_controller
// with a short fall-rate divider.
module tb_note_game_controller;
  logic clk = 1'b0;
  logic reset;

  note_game_controller_if gif();

  note_game_controller #(
    .TICK_DIV   (4),
    .Y_MAX      (779),
    .START_Y    (320),
    .HIT_TOP    (400),
    .HIT_BOT    (475),
    .MAX_MISSES (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (gif.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rst;
    int st;
    int btn;
    int cyc;
    int y;
    int sc;
    int ms;
    int stt;
    int hp;
    int mp;
  } vec_t;

  vec_t vecs[$];
  int   n_run  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_run++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int y, input int sc,
                         input int ms, input int stt, input int hp,
                         input int mp);
    chk({tag, ".note_y"}, int'(gif.note_y), y);
    chk({tag, ".score"}, int'(gif.score), sc);
    chk({tag, ".misses"}, int'(gif.misses), ms);
    chk({tag, ".state"}, int'(gif.state), stt);
    chk({tag, ".hit_pulse"}, int'(gif.hit_pulse), hp);
    chk({tag, ".miss_pulse"}, int'(gif.miss_pulse), mp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic vec_t mk(int rst, int st, int btn, int cyc, int y,
                              int sc, int ms, int stt, int hp, int mp);
    vec_t v;
    v.rst = rst; v.st = st; v.btn = btn; v.cyc = cyc;
    v.y = y; v.sc = sc; v.ms = ms; v.stt = stt; v.hp = hp; v.mp = mp;
    return v;
  endfunction

  initial begin
    reset      = 1'b1;
    gif.start  = 1'b0;
    gif.button = 1'b0;

    //            rst st btn  cyc    y   sc ms st hp mp
    vecs.push_back(mk(1, 0, 0,    2, 320, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1000, 320, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0,    1,   0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,    3,   0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,    1,   1, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,    4,   2, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1588, 399, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1,    1, 399, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,    3, 400, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1,    1, 400, 1, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1,  199, 450, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1316, 779, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,    4,   0, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1900, 475, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1,    1, 475, 2, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1219,   0, 2, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1904, 476, 2, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1,    1, 476, 2, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1215,   0, 2, 1, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0,    1,   0, 2, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 3119,   0, 2, 2, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 3116, 779, 2, 2, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,    4,   0, 2, 3, 2, 0, 1));
    vecs.push_back(mk(0, 0, 1,   50,   0, 2, 3, 2, 0, 0));
    vecs.push_back(mk(0, 1, 0,    1,   0, 0, 0, 1, 0, 0));

    foreach (vecs[i]) begin
      reset      = vecs[i].rst[0];
      gif.start  = vecs[i].st[0];
      gif.button = vecs[i].btn[0];
      cycles(vecs[i].cyc);
      chk_all($sformatf("vec%0d", i), vecs[i].y, vecs[i].sc,
              vecs[i].ms, vecs[i].stt, vecs[i].hp, vecs[i].mp);
    end
    gif.start = 1'b0;

    // saturation: preload score to all ones at note_y 410
    cycles(1640);
    chk_all("sat_pre", 410, 0, 0, 1, 0, 0);
    force dut.score_q = 16'hFFFF;
    cycles(1);
    release dut.score_q;
    chk("sat_force", int'(gif.score), 32'hFFFF);
    gif.button = 1'b1;
    cycles(1);
    chk_all("sat_hit", 410, 32'hFFFF, 0, 1, 1, 0);
    gif.button = 1'b0;

    // restart from PLAY at note_y 450
    cycles(158);
    chk("rs_pre_y", int'(gif.note_y), 450);
    gif.start  = 1'b1;
    gif.button = 1'b1;
    cycles(1);
    gif.start  = 1'b0;
    gif.button = 1'b0;
    chk_all("restart", 0, 0, 0, 1, 0, 0);

    // armed again after restart: hit at 410
    cycles(1640);
    gif.button = 1'b1;
    cycles(1);
    chk_all("rearm_hit", 410, 1, 0, 1, 1, 0);
    gif.button = 1'b0;

    // reset mid-PLAY, then idle hold
    cycles(1);
    reset = 1'b1;
    cycles(1);
    chk_all("mid_reset", 320, 0, 0, 0, 0, 0);
    reset = 1'b0;
    cycles(1000);
    chk_all("idle_hold", 320, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
